cacheline_arbiter: RTL and testbench

Shares the single cacheline adaptor port between the instruction cache and the data cache. It sits between the two cache_control-driven caches and the cacheline adaptor / physical memory. Each cache sees a private, full-line (256-bit) read/write port. The arbiter grants one owner per transaction, steers address, data and strobes to the adaptor, and routes the response back only to the owner.

---
 rtl/cache_arb_pkg.sv | 19 +
 rtl/arb_select.sv | 44 ++++
 rtl/cacheline_arbiter.sv | 127 ++++++++++++
 tb/tb_cacheline_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D cacheline arbiter.
package cache_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_select.sv
// Owner choice for the cacheline arbiter. Policy macro: CACHELINE_ARB_RR_EN
// (defined = round-robin on collision, undefined = fixed D-over-I priority).
module arb_select
    import cache_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   req_any,
    output owner_t winner
);

`ifndef CACHELINE_ARB_RR_EN
    // Fixed priority ignores history; sink it so the port stays uniform.
    logic unused_s;
    assign unused_s = last_owner;
`endif

    // Pick the next owner from the live requests.
    always_comb begin
        req_any = i_req | d_req;
        winner  = OWN_I;
`ifdef CACHELINE_ARB_RR_EN
        if (i_req && d_req) begin
            if (last_owner == OWN_I) begin
                winner = OWN_D;
            end else begin
                winner = OWN_I;
            end
        end else if (d_req) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
`else
        if (d_req) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
`endif
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline adaptor port between the I-cache and D-cache.
// Arbitration policy is selected by CACHELINE_ARB_RR_EN (see arb_select).
module cacheline_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_r;
    owner_t            last_owner_r;
    owner_t            winner_s;
    logic              req_any_s;
    logic              d_req_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [LINE_W-1:0] mem_wdata_s;
    logic              i_resp_s;
    logic              d_resp_s;

    assign d_req_s = d_read | d_write;

    arb_select u_select (
        .i_req      (i_read),
        .d_req      (d_req_s),
        .last_owner (last_owner_r),
        .req_any    (req_any_s),
        .winner     (winner_s)
    );

    // Transaction FSM and last-owner history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_owner_r <= OWN_I;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_any_s) begin
                        last_owner_r <= winner_s;
                        if (winner_s == OWN_D) begin
                            state_r <= GRANT_D;
                        end else begin
                            state_r <= GRANT_I;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT_I: begin
                    if (mem_resp) begin
                        state_r <= RELEASE;
                    end else begin
                        state_r <= GRANT_I;
                    end
                end
                GRANT_D: begin
                    if (mem_resp) begin
                        state_r <= RELEASE;
                    end else begin
                        state_r <= GRANT_D;
                    end
                end
                RELEASE: state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Steer the owner's request to the adaptor; a read+write collision from
    // the D-cache is forwarded as a write only.
    always_comb begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {LINE_W{1'b0}};
        i_resp_s    = 1'b0;
        d_resp_s    = 1'b0;
        case (state_r)
            GRANT_I: begin
                mem_read_s = i_read;
                mem_addr_s = i_addr;
                i_resp_s   = mem_resp;
            end
            GRANT_D: begin
                mem_read_s  = d_read & ~d_write;
                mem_write_s = d_write;
                mem_addr_s  = d_addr;
                mem_wdata_s = d_wdata;
                d_resp_s    = mem_resp;
            end
            default: begin
                mem_read_s = 1'b0;
            end
        endcase
    end

    assign mem_read  = mem_read_s;
    assign mem_write = mem_write_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign i_resp    = i_resp_s;
    assign d_resp    = d_resp_s;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench: directed scenarios plus randomized cache/adaptor traffic
// compared every cycle against a transaction-level ownership model.
module tb_cacheline_arbiter;
    import cache_arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [LW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          mem_resp = 1'b0;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          i_resp, d_resp, mem_read, mem_write;

    always #5 clk = ~clk;

    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: who owns the port (-1 none, 0 I, 1 D), cycles of
    // mandatory quiet time left, and whom the last grant went to.
    int owner = -1, cool = 0, last = 0;
    int grants[$];
    int cnt_read, cnt_write, cnt_iresp, cnt_dresp, cnt_rd_at, cnt_wr_ok;
    logic [AW-1:0] watch_addr = '0;
    logic [LW-1:0] watch_wd = '0, last_i_rdata = '0;
    logic s_rst = 1'b0, s_resp = 1'b0, s_strobe = 1'b0, s_i_resp = 1'b0, s_d_resp = 1'b0;

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        logic [3:0]    exp_strb;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wd;
        int            pick;
        exp_strb = 4'b0; exp_addr = '0; exp_wd = '0; pick = 0;
        if (owner == 0) begin
            exp_strb = {i_read, 1'b0, mem_resp, 1'b0};
            exp_addr = i_addr;
        end else if (owner == 1) begin
            exp_strb = {d_read & ~d_write, d_write, 1'b0, mem_resp};
            exp_addr = d_addr;
            exp_wd   = d_wdata;
        end
        check("strobes", {mem_read, mem_write, i_resp, d_resp}, exp_strb);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_wd);
        check("i_rdata", i_rdata, mem_rdata);
        check("d_rdata", d_rdata, mem_rdata);

        cnt_read  += int'(mem_read);
        cnt_write += int'(mem_write);
        cnt_iresp += int'(i_resp);
        cnt_dresp += int'(d_resp);
        if (mem_read && mem_addr == watch_addr) cnt_rd_at++;
        if (mem_write && mem_addr == watch_addr && mem_wdata == watch_wd) cnt_wr_ok++;
        if (i_resp) last_i_rdata = i_rdata;
        s_rst = rst; s_resp = mem_resp; s_strobe = mem_read | mem_write;
        s_i_resp = i_resp; s_d_resp = d_resp;

        if (!rst) begin
            owner = -1; cool = 0; last = 0;
        end else if (owner >= 0) begin
            if (mem_resp) begin owner = -1; cool = 1; end
        end else if (cool > 0) begin
            cool--;
        end else if (i_read || d_read || d_write) begin
`ifdef CACHELINE_ARB_RR_EN
            if (i_read && (d_read || d_write)) pick = 1 - last;
            else pick = (d_read || d_write) ? 1 : 0;
`else
            pick = (d_read || d_write) ? 1 : 0;
`endif
            owner = pick; last = pick;
            grants.push_back(pick);
        end
    end

    // Behavioural adaptor: resp in the a_lat-th cycle of a strobe.
    int fixed_lat = 4, a_cnt = 0, a_lat = 4;
    bit pat_en = 1'b1;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!s_rst || s_resp) begin
            mem_resp = 1'b0; a_cnt = 0;
        end else if (s_strobe) begin
            a_cnt++;
            if (a_cnt == 1) a_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(5, 2));
            if (a_cnt == a_lat - 1) begin
                mem_resp  = 1'b1;
                mem_rdata = pat_en ? {32{8'hA5}} : rand_line();
            end
        end
    end

    bit rand_en = 1'b0;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic clear();
        grants.delete();
        cnt_read = 0; cnt_write = 0; cnt_iresp = 0; cnt_dresp = 0; cnt_rd_at = 0; cnt_wr_ok = 0;
    endtask

    // Grant order packed as base-4 digits, 1 = I and 2 = D, oldest first.
    function automatic int grant_seq();
        int v = 0;
        foreach (grants[k]) v = v * 4 + grants[k] + 1;
        return v;
    endfunction

    // Caches drop a request after its resp; optionally raise random new ones.
    task automatic run(input int n);
        int k;
        for (int c = 0; c < n; c++) begin
            cyc();
            if (s_i_resp) i_read = 1'b0;
            else if (rand_en && !i_read && $urandom_range(3) == 0) begin
                i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
            end
            if (s_d_resp) begin d_read = 1'b0; d_write = 1'b0; end
            else if (rand_en && !d_read && !d_write && $urandom_range(2) == 0) begin
                k = int'($urandom_range(7));
                d_write = (k < 3); d_read = (k >= 3) || (k == 0);
                d_addr = $urandom & 32'hFFFF_FFE0; d_wdata = rand_line();
            end
        end
    endtask

    logic [LW-1:0] cnt_bytes;

    initial begin
        clear();
        // Reset with both requests pending.
        rst = 1'b0; i_read = 1'b1; d_read = 1'b1;
        cyc();
        settle();
        check("rst_state", dut.state_r, IDLE);
        check("rst_outs", {mem_read, mem_write, i_resp, d_resp, |mem_addr, |mem_wdata}, 6'b0);
        cyc();
        rst = 1'b1;
        cyc();
        settle();
        check("rst_grant", {mem_read, mem_addr}, {1'b1, 32'h0});
        run(16);
        check("rst_order", grant_seq(), 9);

        // Lone I read.
        clear();
        watch_addr = 32'h0000_1000; i_addr = 32'h0000_1000; i_read = 1'b1;
        run(10);
        check("i_rd_cycles", cnt_rd_at, 4);
        check("i_resp_cnt", cnt_iresp, 1);
        check("i_dresp_cnt", cnt_dresp, 0);
        check("i_rdata_pat", last_i_rdata, {32{8'hA5}});

        // Lone D write-back with counting bytes.
        clear();
        for (int b = 0; b < LW / 8; b++) cnt_bytes[8*b +: 8] = 8'(b);
        watch_addr = 32'h8000_0040; watch_wd = cnt_bytes;
        d_addr = 32'h8000_0040; d_wdata = cnt_bytes; d_write = 1'b1;
        run(10);
        check("d_wr_ok", cnt_wr_ok, 4);
        check("d_wr_read", cnt_read, 0);
        check("d_resp_cnt", cnt_dresp, 1);

        // Collision from a fresh reset, then again.
        rst = 1'b0; cyc(); rst = 1'b1;
        clear();
        i_addr = 32'h100; d_addr = 32'h200; i_read = 1'b1; d_read = 1'b1;
        run(16);
        check("coll1_order", grant_seq(), 9);
        clear();
        i_read = 1'b1; d_read = 1'b1;
        run(16);
        check("coll2_order", grant_seq(), 9);

        // Lone D, then a collision: policies diverge here.
        clear();
        d_read = 1'b1;
        run(10);
        i_read = 1'b1; d_read = 1'b1;
        run(16);
`ifdef CACHELINE_ARB_RR_EN
        check("coll3_order", grant_seq(), 38);
`else
        check("coll3_order", grant_seq(), 41);
`endif

        // Illegal read+write from D.
        clear();
        d_read = 1'b1; d_write = 1'b1;
        run(10);
        check("ill_read", cnt_read, 0);
        check("ill_write", cnt_write, 4);

        // Reset in the middle of a D grant.
        fixed_lat = 6;
        d_read = 1'b1;
        cyc(); cyc();
        settle();
        check("mid_pre", {mem_read, mem_addr}, {1'b1, 32'h200});
        cyc();
        rst = 1'b0; clear();
        cyc();
        settle();
        check("mid_strb", {mem_read, mem_write, d_resp}, 3'b0);
        cyc();
        rst = 1'b1; d_read = 1'b0;
        run(6);
        check("mid_dresp", cnt_dresp, 0);

        // Randomized traffic, then drain.
        fixed_lat = 0; pat_en = 1'b0; rand_en = 1'b1;
        run(3000);
        rand_en = 1'b0;
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
